mat_out_serializer: RTL and testbench

MAT_OUT_SERIALIZER -- requirements
Module: mat_out_serializer

---
 rtl/mat_pkg.sv | 18 +
 rtl/mat_out_serializer.sv | 110 +++++++++++
 tb/tb_mat_out_serializer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix result serializer.
// Default geometry, FSM state type and index sizing helper.
package mat_pkg;

  localparam int N_ROWS_DEF    = 2;
  localparam int N_COLUMNS_DEF = 2;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Index width for n elements, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mat_out_serializer.sv
// Captures a finished result matrix on the rising edge of mult_done
// and streams it row-major over a valid/ready port.
module mat_out_serializer
  import mat_pkg::*;
#(
  parameter int N_ROWS    = N_ROWS_DEF,
  parameter int N_COLUMNS = N_COLUMNS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mult_done,
  input  logic signed [31:0] mat_out [0:N_ROWS-1][0:N_COLUMNS-1],
  output logic signed [31:0] data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               data_last,
  output logic               busy,
  output logic               overrun
);

  localparam int TOTAL = N_ROWS * N_COLUMNS;
  localparam int IW    = idx_width(TOTAL);
  localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);

  state_t             state_q;
  state_t             state_nx;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      idx_nx;
  logic               md_q;
  logic               ovr_q;
  logic               ovr_nx;
  logic               capture;
  logic               start;
  logic               xfer;
  logic signed [31:0] buf_q [0:TOTAL-1];

  // Next-state, capture decision and stream outputs.
  always_comb begin
    state_nx   = state_q;
    idx_nx     = idx_q;
    ovr_nx     = ovr_q;
    capture    = 1'b0;
    data_valid = 1'b0;
    busy       = 1'b0;
    data_last  = 1'b0;
    data_out   = '0;
    start      = mult_done & ~md_q;
    xfer       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          idx_nx   = '0;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        data_valid = 1'b1;
        busy       = 1'b1;
        data_out   = buf_q[idx_q];
        data_last  = (idx_q == LAST);
        xfer       = data_ready;
        if (xfer && data_last) begin
          idx_nx = '0;
          if (start) begin
            capture = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_nx = idx_q + 1'b1;
          end
          if (start) begin
            ovr_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, index, edge detector, sticky flag and capture buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      md_q    <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      md_q    <= mult_done;
      ovr_q   <= ovr_nx;
      if (capture) begin
        for (int r = 0; r < N_ROWS; r++) begin
          for (int c = 0; c < N_COLUMNS; c++) begin
            buf_q[r*N_COLUMNS+c] <= mat_out[r][c];
          end
        end
      end
    end
  end

  assign overrun = ovr_q;

endmodule

// File: tb/tb_mat_out_serializer.sv
// Bench for mat_out_serializer: directed tables, corner sequences
// and random traffic against a queue-based reference model.
module tb_mat_out_serializer;

  logic               clk = 1'b0;
  logic               reset;
  logic               mult_done;
  logic signed [31:0] mat [0:1][0:1];
  logic signed [31:0] data_out;
  logic               data_valid;
  logic               data_ready;
  logic               data_last;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;

  int m_q[$];
  bit m_ovr;
  bit m_mdq;

  typedef struct {
    bit md;
    bit rdy;
    bit ev;
    int ed;
    bit el;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  mat_out_serializer #(.N_ROWS(2), .N_COLUMNS(2)) dut (
    .clk(clk),
    .reset(reset),
    .mult_done(mult_done),
    .mat_out(mat),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_last(data_last),
    .busy(busy),
    .overrun(overrun)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_mat(input int a, input int b, input int c, input int d);
    mat[0][0] = a;
    mat[0][1] = b;
    mat[1][0] = c;
    mat[1][1] = d;
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ovr = 1'b0;
    m_mdq = 1'b0;
  endfunction

  // One clock edge of the expected behaviour, from the input values.
  function automatic void model_step();
    bit st;
    bit act;
    st = mult_done && !m_mdq;
    m_mdq = mult_done;
    act = m_q.size() > 0;
    if (act && data_ready) void'(m_q.pop_front());
    if (st) begin
      if (m_q.size() == 0) begin
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            m_q.push_back(int'(mat[r][c]));
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  task automatic cmp_model(input string tag);
    int ed;
    ed = (m_q.size() > 0) ? m_q[0] : 0;
    chk({tag, ".valid"}, int'(data_valid), int'(m_q.size() > 0));
    chk({tag, ".busy"}, int'(busy), int'(m_q.size() > 0));
    chk({tag, ".data"}, int'(data_out), ed);
    chk({tag, ".last"}, int'(data_last), int'(m_q.size() == 1));
    chk({tag, ".overrun"}, int'(overrun), int'(m_ovr));
  endtask

  task automatic tick(input string tag);
    if (data_valid && data_ready) xfer_cnt++;
    @(posedge clk);
    if (!reset) model_step();
    #1;
    cmp_model(tag);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    cmp_model({tag, ".rst"});
    @(posedge clk);
    #1;
    cmp_model({tag, ".rsthold"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mult_done = 1'b0;
    data_ready = 1'b0;
    set_mat(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_model("reset");
    chk("reset.data", int'(data_out), 0);
    reset = 1'b0;
    tick("idle");

    // Capture/stream, then backpressure with mult_done held high.
    tbl[0]  = '{1, 1, 1, 1, 0};
    tbl[1]  = '{1, 1, 1, 2, 0};
    tbl[2]  = '{1, 1, 1, 3, 0};
    tbl[3]  = '{1, 1, 1, 4, 1};
    tbl[4]  = '{1, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 1, 0};
    tbl[7]  = '{1, 0, 1, 1, 0};
    tbl[8]  = '{1, 0, 1, 1, 0};
    tbl[9]  = '{1, 1, 1, 2, 0};
    tbl[10] = '{1, 1, 1, 3, 0};
    tbl[11] = '{1, 1, 1, 4, 1};
    tbl[12] = '{0, 1, 0, 0, 0};
    set_mat(1, 2, 3, 4);
    xfer_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      mult_done = tbl[i].md;
      data_ready = tbl[i].rdy;
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.valid", i), int'(data_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d.data", i), int'(data_out), tbl[i].ed);
      chk($sformatf("tbl%0d.last", i), int'(data_last), int'(tbl[i].el));
      if (i == 5) chk("held.xfers", xfer_cnt, 4);
    end

    // Held level for 20 cycles: one capture only.
    xfer_cnt = 0;
    mult_done = 1'b1;
    data_ready = 1'b1;
    repeat (20) tick("held");
    chk("held20.xfers", xfer_cnt, 4);
    chk("held20.overrun", int'(overrun), 0);
    mult_done = 1'b0;
    tick("held.fall");

    // Overrun: second rise during the second transfer.
    set_mat(1, 2, 3, 4);
    mult_done = 1'b1;
    tick("ovr.e0");
    mult_done = 1'b0;
    set_mat(9, 9, 9, 9);
    tick("ovr.e1");
    mult_done = 1'b1;
    set_mat(5, 6, 7, 8);
    tick("ovr.e2");
    chk("ovr.data3", int'(data_out), 3);
    chk("ovr.flag", int'(overrun), 1);
    tick("ovr.e3");
    chk("ovr.data4", int'(data_out), 4);
    mult_done = 1'b0;
    repeat (3) tick("ovr.tail");
    chk("ovr.sticky", int'(overrun), 1);
    async_reset("ovr");
    tick("ovr.post");

    // Back-to-back: rise lands on the last transfer.
    set_mat(1, 2, 3, 4);
    mult_done = 1'b1;
    tick("b2b.e0");
    mult_done = 1'b0;
    tick("b2b.e1");
    tick("b2b.e2");
    tick("b2b.e3");
    chk("b2b.last", int'(data_last), 1);
    mult_done = 1'b1;
    set_mat(5, 6, 7, 8);
    tick("b2b.e4");
    chk("b2b.valid", int'(data_valid), 1);
    chk("b2b.data5", int'(data_out), 5);
    chk("b2b.overrun", int'(overrun), 0);
    mult_done = 1'b0;
    repeat (4) tick("b2b.tail");
    chk("b2b.idle", int'(data_valid), 0);

    // Reset mid-stream with overrun set; nothing resumes.
    set_mat(1, 2, 3, 4);
    mult_done = 1'b1;
    tick("rms.e0");
    mult_done = 1'b0;
    tick("rms.e1");
    mult_done = 1'b1;
    tick("rms.e2");
    chk("rms.ovr", int'(overrun), 1);
    mult_done = 1'b0;
    async_reset("rms");
    chk("rms.valid", int'(data_valid), 0);
    chk("rms.busy", int'(busy), 0);
    chk("rms.overrun", int'(overrun), 0);
    repeat (4) tick("rms.quiet");
    chk("rms.still", int'(data_valid), 0);

    // mult_done already high at reset release starts a capture.
    reset = 1'b1;
    model_reset();
    mult_done = 1'b1;
    set_mat(11, 12, 13, 14);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("rel.e0");
    chk("rel.valid", int'(data_valid), 1);
    chk("rel.data", int'(data_out), 11);
    repeat (6) tick("rel.tail");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) mult_done = ~mult_done;
      data_ready = ($urandom_range(0, 3) != 0);
      set_mat($urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 79) == 0) async_reset("rnd");
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
